// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs multi-cycle mult/div
// with fixed latency, executes mthi/mtlo and requests D-stage stalls.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC) > 4) ? $clog2(MAXC) : 4;
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [31:0]   a_r, a_s, b_r, b_s;
  logic [2:0]    op_r, op_s;
  logic [31:0]   hi_r, hi_s, lo_r, lo_s;

  logic [63:0]   prod_signed_s, prod_unsigned_s;
  logic          a_neg_s, b_neg_s;
  logic [31:0]   a_mag_s, b_mag_s, b_div_s, uq_s, ur_s, quo_s, rem_s;

  // Datapath on latched operands; division runs on magnitudes then fixes signs.
  always_comb begin
    prod_signed_s   = $signed({{32{a_r[31]}}, a_r}) * $signed({{32{b_r[31]}}, b_r});
    prod_unsigned_s = {32'd0, a_r} * {32'd0, b_r};
    a_neg_s = (op_r == 3'd2) & a_r[31];
    b_neg_s = (op_r == 3'd2) & b_r[31];
    a_mag_s = a_neg_s ? (32'd0 - a_r) : a_r;
    b_mag_s = b_neg_s ? (32'd0 - b_r) : b_r;
    // Divisor of zero is replaced to keep the unused quotient defined.
    b_div_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
    uq_s    = a_mag_s / b_div_s;
    ur_s    = a_mag_s % b_div_s;
    quo_s   = (a_neg_s ^ b_neg_s) ? (32'd0 - uq_s) : uq_s;
    rem_s   = a_neg_s ? (32'd0 - ur_s) : ur_s;
  end

  // Next-state logic: launch, count down, retire results, mthi/mtlo.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    a_s     = a_r;
    b_s     = b_r;
    op_s    = op_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          case (mdop)
            3'd0, 3'd1: begin
              a_s = A; b_s = B; op_s = mdop;
              cnt_s = MULT_LAST;
              state_s = RUN;
            end
            3'd2, 3'd3: begin
              a_s = A; b_s = B; op_s = mdop;
              cnt_s = DIV_LAST;
              state_s = RUN;
            end
            3'd4:    hi_s = A;
            3'd5:    lo_s = A;
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = IDLE;
          case (op_r)
            3'd0: {hi_s, lo_s} = prod_signed_s;
            3'd1: {hi_s, lo_s} = prod_unsigned_s;
            3'd2, 3'd3: begin
              if (b_r != 32'd0) begin
                hi_s = rem_s;
                lo_s = quo_s;
              end else begin
                hi_s = hi_r;
              end
            end
            default: hi_s = hi_r;
          endcase
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and HI/LO registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      op_r    <= 3'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      a_r     <= a_s;
      b_r     <= b_s;
      op_r    <= op_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
    end
  end

  assign busy  = (state_r == RUN);
  assign hi    = hi_r;
  assign lo    = lo_r;
  assign stall = md_use_d & (busy | (start & (mdop <= 3'd3)));

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO and busy length,
// a negedge monitor checks them each time busy falls.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset, start, md_use_d;
  logic [2:0]  mdop;
  logic [31:0] A, B;
  logic        busy, stall;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop), .A(A), .B(B),
    .md_use_d(md_use_d), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: count busy cycles, compare against the scoreboard when busy falls.
  initial begin
    logic prev_busy;
    int   bcnt;
    exp_t e;
    prev_busy = 1'b0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        bcnt = 0;
      end else begin
        if (busy) bcnt++;
        if (prev_busy && !busy) begin
          if (sb.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
            check("busy_cycles", bcnt, e.n);
          end
          bcnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int n);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.n = n;
    sb.push_back(e);
    start = 1'b1; mdop = op; A = a; B = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_use_d = 1'b0; mdop = 3'd0; A = 32'd0; B = 32'd0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);

    // Same-cycle stall on a launching mult, then stall throughout RUN.
    md_use_d = 1'b1; start = 1'b1; mdop = 3'd0; A = 32'hFFFFFFFE; B = 32'd3;
    #1;
    check("stall_on_start", {31'd0, stall}, 32'd1);
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFA, n: 5});
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_in_run", {30'd0, busy, stall}, 32'd3);
      tick();
    end
    check("stall_on_fall", {30'd0, busy, stall}, 32'd0);
    md_use_d = 1'b0;

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    check("no_stall_without_use", {30'd0, busy, stall}, 32'd2);
    wait_idle();
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    wait_idle();
    issue(3'd3, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    wait_idle();
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    wait_idle();
    issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    wait_idle();
    issue(3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10);
    wait_idle();
    issue(3'd0, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 5);
    wait_idle();

    // Start while busy is ignored; operand changes mid-run have no effect.
    issue(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5);
    start = 1'b1; mdop = 3'd5; A = 32'h1234;
    tick();
    start = 1'b0; A = 32'h99; B = 32'h77;
    wait_idle();

    start = 1'b1; mdop = 3'd5; A = 32'h55;
    tick();
    start = 1'b0;
    check("mtlo_lo", lo, 32'h55);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_hi_kept", hi, 32'd0);
    start = 1'b1; mdop = 3'd4; A = 32'hABCD;
    tick();
    start = 1'b0;
    check("mthi_hi", hi, 32'hABCD);
    start = 1'b1; mdop = 3'd7; A = 32'hDEAD;
    tick();
    start = 1'b0;
    check("reserved_hi", hi, 32'hABCD);
    check("reserved_lo", lo, 32'h55);
    check("reserved_busy", {31'd0, busy}, 32'd0);

    // Reset three cycles into a divide aborts it without writing HI/LO.
    start = 1'b1; mdop = 3'd2; A = 32'd100; B = 32'd3;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    start = 1'b1; mdop = 3'd0; A = 32'd5; B = 32'd5;
    tick();
    start = 1'b0;
    reset = 1'b0;
    check("start_with_reset", {31'd0, busy}, 32'd0);
    repeat (12) tick();
    check("no_late_hi", hi, 32'd0);
    check("no_late_lo", lo, 32'd0);
    check("no_late_busy", {31'd0, busy}, 32'd0);

    repeat (2) tick();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
